// File: rtl/switch_pkg.sv
// Shared switch constants, descriptor bundle and ingress FSM states.
// Imported by the ingress writer and its neighbours.
package switch_pkg;

  localparam int BLOCK_BYTES = 32;
  localparam int BLOCK_WORDS = 8;
  localparam int ADDR_W      = 10;
  localparam int LEN_W       = 11;
  localparam int BLK_W       = 6;
  localparam int PORT_W      = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    logic [PORT_W-1:0] dest;
  } desc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALLOC = 3'd1,
    WRITE = 3'd2,
    DROP  = 3'd3,
    DESC  = 3'd4
  } state_t;

endpackage

// File: rtl/pkt_ingress_writer_if.sv
// Ingress beat stream: header beat plus payload beats.
// valid/ready handshake, sop on header, eop on last payload.
interface pkt_ingress_writer_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [DATA_W-1:0] data;

  modport master (
    output valid, sop, eop, data,
    input  ready
  );

  modport slave (
    input  valid, sop, eop, data,
    output ready
  );
endinterface

// File: rtl/pkt_ingress_writer.sv
// Ingress writer: allocates blocks, stores payload words,
// emits one descriptor per stored packet, drops misfits.
module pkt_ingress_writer #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 10,
  parameter int LEN_W       = 11,
  parameter int BLK_W       = 6,
  parameter int PORT_W      = 2,
  localparam int WI_W       = $clog2(BLOCK_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  pkt_ingress_writer_if.slave    ing,
  input  logic [BLK_W-1:0]       free_blocks,
  output logic                   alloc_req,
  output logic [BLK_W-1:0]       alloc_remaining,
  input  logic                   alloc_gnt,
  input  logic [ADDR_W-1:0]      alloc_addr,
  output logic                   dmem_we,
  output logic [ADDR_W+WI_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  output logic                   desc_valid,
  input  logic                   desc_ready,
  output logic [ADDR_W-1:0]      desc_start,
  output logic [LEN_W-1:0]       desc_len,
  output logic [PORT_W-1:0]      desc_dest,
  output logic                   len_err,
  output logic [15:0]            drop_count
);
  import switch_pkg::*;

  localparam int BEAT_B  = DATA_W / 8;
  localparam int BEAT_SH = $clog2(BEAT_B);
  localparam int BLK_SH  = $clog2(BLOCK_WORDS * BEAT_B);
  localparam int LW1     = LEN_W + 1;
  localparam logic [WI_W-1:0]  LAST_W  = WI_W'(BLOCK_WORDS - 1);
  localparam logic [BLK_W-1:0] ONE_B   = BLK_W'(1);
  localparam logic [LW1-1:0]   MAX_BLK = LW1'((1 << BLK_W) - 1);

  state_t state, state_n;

  logic [LEN_W-1:0]  len_q;
  logic [PORT_W-1:0] dest_q;
  logic [BLK_W-1:0]  rem_q;
  logic [ADDR_W-1:0] blk_q;
  logic [ADDR_W-1:0] start_q;
  logic [WI_W-1:0]   widx_q;
  logic [LW1-1:0]    beats_q;
  logic              first_q;
  logic              pend_q;
  logic              rej_q;
  logic              rdy_q;

  logic [LEN_W-1:0]  hdr_len;
  logic [PORT_W-1:0] hdr_dest;
  logic [LW1-1:0]    blocks;
  logic [LW1-1:0]    need;
  logic [LW1-1:0]    beats_n;
  logic              hdr_drop;
  logic              acc;
  logic              last_w;
  logic              drop_sat;

  assign hdr_len  = ing.data[LEN_W-1:0];
  assign hdr_dest = ing.data[16+PORT_W-1:16];
  assign blocks   = ({1'b0, hdr_len} + LW1'(BLOCK_WORDS*BEAT_B - 1)) >> BLK_SH;
  assign need     = ({1'b0, len_q} + LW1'(BEAT_B - 1)) >> BEAT_SH;
  assign beats_n  = beats_q + LW1'(1);
  assign hdr_drop = (hdr_len == '0) || (blocks > MAX_BLK)
                 || (blocks > LW1'(free_blocks));
  assign acc      = ing.valid && ing.ready;
  assign last_w   = (widx_q == LAST_W);
  assign drop_sat = (drop_count == 16'hFFFF);

  assign ing.ready       = rdy_q && !reset;
  assign alloc_req       = (state == ALLOC);
  assign alloc_remaining = alloc_req ? rem_q : '0;
  assign desc_valid      = (state == DESC);
  assign desc_start      = start_q;
  assign desc_len        = len_q;
  assign desc_dest       = dest_q;

  // Next-state decode for the packet FSM.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (acc && ing.sop)
          state_n = !hdr_drop ? ALLOC : (ing.eop ? IDLE : DROP);
      ALLOC:
        if (alloc_gnt) state_n = WRITE;
      WRITE:
        if (acc) begin
          if (ing.eop)     state_n = DESC;
          else if (last_w) state_n = (rem_q == ONE_B) ? DROP : ALLOC;
        end
      DROP:
        if (acc && ing.eop) state_n = pend_q ? DESC : IDLE;
      DESC:
        if (desc_ready) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // State, handshake readiness and packet datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      len_q      <= '0;
      dest_q     <= '0;
      rem_q      <= '0;
      blk_q      <= '0;
      start_q    <= '0;
      widx_q     <= '0;
      beats_q    <= '0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      rej_q      <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      len_err    <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_n;
      rdy_q   <= (state_n == IDLE) || (state_n == WRITE)
              || (state_n == DROP);
      dmem_we <= 1'b0;
      len_err <= 1'b0;
      unique case (state)
        IDLE:
          if (acc && ing.sop) begin
            len_q   <= hdr_len;
            dest_q  <= hdr_dest;
            rem_q   <= blocks[BLK_W-1:0];
            first_q <= 1'b1;
            beats_q <= '0;
            pend_q  <= 1'b0;
            rej_q   <= hdr_drop;
            if (hdr_drop && ing.eop && !drop_sat)
              drop_count <= drop_count + 16'd1;
          end
        ALLOC:
          if (alloc_gnt) begin
            blk_q  <= alloc_addr;
            widx_q <= '0;
            if (first_q) begin
              start_q <= alloc_addr;
              first_q <= 1'b0;
            end
          end
        WRITE:
          if (acc) begin
            dmem_we    <= 1'b1;
            dmem_addr  <= {blk_q, widx_q};
            dmem_wdata <= ing.data;
            widx_q     <= widx_q + 1'b1;
            beats_q    <= beats_n;
            if (ing.eop) begin
              len_err <= (rem_q != ONE_B) || (beats_n != need);
            end else if (last_w) begin
              rem_q <= rem_q - ONE_B;
              if (rem_q == ONE_B) begin
                len_err <= 1'b1;
                pend_q  <= 1'b1;
              end
            end
          end
        DROP:
          if (acc && ing.eop && rej_q && !drop_sat)
            drop_count <= drop_count + 16'd1;
        DESC: ;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pkt_ingress_writer.md
Name: pkt_ingress_writer

Overview:
- Upstream feeder of the control-memory block allocator. Accepts a packet stream of one header beat plus payload beats.
- Requests data-memory blocks one at a time from the allocator, using a 1-block granularity of 32 B = 8 words.
- Writes payload words into data memory at {block, word}.
- Emits one descriptor per stored packet (start block, byte length, destination) to the output-queue stage.
- Drops packets that cannot fit.

Parameters:
- DATA_W, 32, payload word width.
- BLOCK_WORDS, 8, words per data-memory block; power of 2.
- ADDR_W, 10, control-memory / block address width.
- LEN_W, 11, packet byte-length field width.
- BLK_W, 6, block-count width; max 63 blocks per packet.
- PORT_W, 2, destination port field width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_data  in  DATA_W  beat data; on the header beat, [LEN_W-1:0]=byte length and [16+PORT_W-1:16]=destination.
- in_sop  in  1  marks the header beat.
- in_eop  in  1  marks the last payload beat.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- free_blocks  in  BLK_W  current count of free blocks reported by the allocator.
- alloc_req  out  1  block request; held high until granted.
- alloc_remaining  out  BLK_W  blocks still needed, counting the one being requested.
- alloc_gnt  in  1  single-cycle grant.
- alloc_addr  in  ADDR_W  granted block; valid with alloc_gnt.
- dmem_we  out  1  data-memory write enable.
- dmem_addr  out  ADDR_W+3  equals {block, word_idx}.
- dmem_wdata  out  DATA_W  write data.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  descriptor accepted.
- desc_start  out  ADDR_W  first block of the packet.
- desc_len  out  LEN_W  byte length taken from the header.
- desc_dest  out  PORT_W  destination port.
- len_err  out  1  one-cycle pulse when eop position disagrees with the header length.
- drop_count  out  16  saturating count of dropped packets.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready, alloc_req, alloc_remaining, dmem_*, desc_*, len_err and drop_count all go to 0.
  - in_ready stays 0 during the reset cycle.
  - A reset mid-packet abandons the packet. Blocks already granted are not returned; the allocator is reset by the same signal.
- in_ready is a function of the state register only, never of in_valid.
- Block count: blocks = ceil(len/32) = (len+31)>>5, computed at LEN_W+1 bits, then checked against 63.
- IDLE:
  - in_ready=1.
  - Accepting a beat with in_sop=1 latches len, dest, and blocks into remaining.
  - Drop when len==0, blocks>63, or blocks>free_blocks (value sampled the same cycle). A drop goes to DROP if in_eop=0; otherwise drop_count++ and stay in IDLE.
  - Otherwise go to ALLOC with first=1.
  - Non-sop beats arriving in IDLE are consumed and discarded, with no other effect.
- ALLOC:
  - in_ready=0, alloc_req=1, alloc_remaining=remaining.
  - On alloc_gnt: latch blk=alloc_addr. If first, desc_start<=alloc_addr and first<=0. word_idx<=0, then go to WRITE.
- WRITE:
  - in_ready=1.
  - An accepted beat registers dmem_we=1, dmem_addr={blk,word_idx} and dmem_wdata=in_data on the next cycle (latency 1). Then word_idx++.
  - If in_eop: go to DESC. Pulse len_err if remaining!=1 or beat count != ceil(len/4).
  - Else if word_idx==BLOCK_WORDS-1: remaining--. If remaining was 1, go to DROP, pulse len_err, and keep the descriptor pending. Otherwise go to ALLOC.
- DROP:
  - in_ready=1; consume beats until eop.
  - On eop: drop_count++ if this was a rejected packet; go to DESC if a descriptor is pending; otherwise go to IDLE.
- DESC:
  - in_ready=0, desc_valid=1, descriptor fields held stable.
  - On desc_ready, go to IDLE; desc_valid drops the next cycle.
  - desc_valid never asserts before the final dmem write has been issued.
- drop_count saturates at 16'hFFFF.
- Simultaneous alloc_gnt outside ALLOC is ignored.

Decomposition:
- Shared package `switch_pkg` holds:
  - constants BLOCK_BYTES=32, BLOCK_WORDS, ADDR_W, LEN_W, BLK_W, PORT_W;
  - typedef desc_t {start, len, dest};
  - FSM enum state_t {IDLE, ALLOC, WRITE, DROP, DESC}.
- No sub-module. Single FSM plus datapath registers.

Test Plan:
1. len=64, dest=2, free_blocks=10, grants 5 then 9, 16 payload beats -> dmem_addr 40..47 then 72..79, alloc_remaining 2 then 1, desc start=5 len=64 dest=2, len_err=0.
2. len=100 (4 blocks), free_blocks=3 -> alloc_req never asserts, in_ready=1 until eop, drop_count=1, no dmem_we, no desc.
3. len=4, single payload beat with eop -> one alloc_req with alloc_remaining=1, grant 7 -> one write at addr 56, desc len=4.
4. alloc_gnt delayed 3 cycles -> alloc_req held and alloc_remaining constant for those cycles, in_ready=0, no writes.
5. desc_ready low for 5 cycles after packet -> desc_valid and fields stable, in_ready=0, next header not accepted until a cycle after the handshake.
6. reset asserted mid-WRITE (3rd beat) -> next cycle all outputs 0 and state IDLE; a following len=32 packet is stored correctly. Also len=0 header -> dropped, drop_count increments.
